// File: rtl/wav_dfi_upd_lp_sched.sv
// DFI ctrlupd / phyupd / phymstr / lp_ctrl handshake scheduler: one grant at a time, timed windows.
// Optional WAV_DFI_LP_DATA_EN adds the lp_data channel sequenced alongside lp_ctrl.
module wav_dfi_upd_lp_sched #(
    parameter int TCTRLUPD_MIN = 4,
    parameter int TCTRLUPD_MAX = 64,
    parameter int TPHYUPD_RESP = 32,
    parameter int TLP_RESP     = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init_start,
    input  logic       init_complete,
    input  logic       upd_trig,
    output logic       upd_done,
    output logic       ctrlupd_req,
    input  logic       ctrlupd_ack,
    input  logic       phyupd_req,
    output logic       phyupd_ack,
    input  logic       phymstr_req,
    output logic       phymstr_ack,
    input  logic       lp_trig,
    input  logic [5:0] lp_wakeup_cfg,
    output logic       lp_ctrl_req,
    output logic [5:0] lp_ctrl_wakeup,
    input  logic       lp_ctrl_ack,
`ifdef WAV_DFI_LP_DATA_EN
    output logic       lp_data_req,
    output logic [5:0] lp_data_wakeup,
    input  logic       lp_data_ack,
`endif
    output logic       mc_quiesce,
    input  logic       mc_idle,
    output logic [2:0] err_timeout
);
    typedef enum logic [3:0] {
        IDLE, CU_REQ, CU_HOLD, CU_WAIT, DRAIN, PU_ACK, PM_ACK, LP_REQ, LP_ACT, LP_EXIT
    } state_t;

    localparam logic [CNT_W-1:0] CU_HOLD_END = CNT_W'(TCTRLUPD_MIN - 1);
    localparam logic [CNT_W-1:0] CU_TO_END   = CNT_W'(TCTRLUPD_MAX - 1);
    // Decide two cycles early so the ack is on the wire TPHYUPD_RESP cycles after the req rise.
    localparam logic [CNT_W-1:0] PU_TO_END   = CNT_W'(TPHYUPD_RESP - 2);
    localparam logic [CNT_W-1:0] LP_TO_END   = CNT_W'(TLP_RESP - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             drain_pm, drain_pm_nx;
    logic [2:0]       err_set;
    logic             done_nx;
    logic             grant_ok;
    logic             lp_ack_all, lp_ack_none;
    logic [5:0]       wakeup_q;

    assign grant_ok = init_complete && !init_start;

`ifdef WAV_DFI_LP_DATA_EN
    logic ctrl_seen, data_seen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_seen <= 1'b0;
            data_seen <= 1'b0;
        end else if (state != LP_REQ) begin
            ctrl_seen <= 1'b0;
            data_seen <= 1'b0;
        end else begin
            ctrl_seen <= ctrl_seen | lp_ctrl_ack;
            data_seen <= data_seen | lp_data_ack;
        end
    end

    assign lp_ack_all     = (ctrl_seen | lp_ctrl_ack) & (data_seen | lp_data_ack);
    assign lp_ack_none    = !lp_ctrl_ack && !lp_data_ack;
    assign lp_data_req    = lp_ctrl_req;
    assign lp_data_wakeup = wakeup_q;
`else
    assign lp_ack_all  = lp_ctrl_ack;
    assign lp_ack_none = !lp_ctrl_ack;
`endif

    always_comb begin
        state_nx    = state;
        drain_pm_nx = drain_pm;
        err_set     = 3'b000;
        done_nx     = 1'b0;
        case (state)
            IDLE: if (grant_ok) begin
                if (phymstr_req) begin
                    state_nx    = DRAIN;
                    drain_pm_nx = 1'b1;
                end else if (phyupd_req) begin
                    state_nx    = DRAIN;
                    drain_pm_nx = 1'b0;
                end else if (upd_trig && !upd_done) begin
                    // upd_done still high means the MC has not yet seen the end of the last update
                    state_nx = CU_REQ;
                end else if (lp_trig) begin
                    state_nx = LP_REQ;
                end
            end
            CU_REQ: begin
                if (ctrlupd_ack) begin
                    state_nx = CU_HOLD;
                end else if (cnt == CU_TO_END) begin
                    state_nx   = IDLE;
                    err_set[0] = 1'b1;
                    done_nx    = 1'b1;
                end
            end
            CU_HOLD: if (cnt == CU_HOLD_END) state_nx = CU_WAIT;
            CU_WAIT: begin
                if (!ctrlupd_ack) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_pm ? !phymstr_req : !phyupd_req) begin
                    state_nx = IDLE;
                end else if (mc_idle) begin
                    state_nx = drain_pm ? PM_ACK : PU_ACK;
                end else if (cnt == PU_TO_END) begin
                    state_nx   = drain_pm ? PM_ACK : PU_ACK;
                    err_set[1] = 1'b1;
                end
            end
            PU_ACK: if (!phyupd_req) state_nx = IDLE;
            PM_ACK: if (!phymstr_req) state_nx = IDLE;
            LP_REQ: begin
                if (lp_ack_all) begin
                    state_nx = LP_ACT;
                end else if (cnt == LP_TO_END) begin
                    state_nx   = IDLE;
                    err_set[2] = 1'b1;
                end
            end
            LP_ACT:  if (!lp_trig || phyupd_req || phymstr_req) state_nx = LP_EXIT;
            LP_EXIT: if (lp_ack_none) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // DFI init aborts everything silently; an unfinished ctrlupd is retried later
        if (init_start) begin
            state_nx = IDLE;
            err_set  = 3'b000;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            drain_pm    <= 1'b0;
            upd_done    <= 1'b0;
            err_timeout <= 3'b000;
            wakeup_q    <= 6'd0;
        end else begin
            state       <= state_nx;
            drain_pm    <= drain_pm_nx;
            upd_done    <= done_nx;
            err_timeout <= err_timeout | err_set;
            if (state_nx != state)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + CNT_W'(1);
            if (state == IDLE && state_nx == LP_REQ)
                wakeup_q <= lp_wakeup_cfg;
        end
    end

    // Masking with init_start keeps the DFI outputs low in the very cycle init begins.
    assign ctrlupd_req    = !init_start && (state == CU_REQ || state == CU_HOLD);
    assign phyupd_ack     = !init_start && (state == PU_ACK);
    assign phymstr_ack    = !init_start && (state == PM_ACK);
    assign lp_ctrl_req    = !init_start && (state == LP_REQ || state == LP_ACT);
    assign lp_ctrl_wakeup = wakeup_q;
    assign mc_quiesce     = !init_start && (state == DRAIN || state == PU_ACK || state == PM_ACK);

endmodule

// File: tb/tb_wav_dfi_upd_lp_sched.sv
// Scoreboard bench: stimulus queues expected output-change events (cycle + output vector),
// a negedge monitor pops and compares them whenever the DUT outputs change.
module tb_wav_dfi_upd_lp_sched;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       init_start = 1'b0, init_complete = 1'b0;
    logic       upd_trig = 1'b0, ctrlupd_ack = 1'b0;
    logic       phyupd_req = 1'b0, phymstr_req = 1'b0;
    logic       lp_trig = 1'b0, lp_ctrl_ack = 1'b0, mc_idle = 1'b0;
    logic [5:0] lp_wakeup_cfg = 6'd0;
    logic       upd_done, ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, mc_quiesce;
    logic [5:0] lp_ctrl_wakeup;
    logic [2:0] err_timeout;

    wav_dfi_upd_lp_sched dut (
        .clock(clock), .reset(reset), .init_start(init_start), .init_complete(init_complete),
        .upd_trig(upd_trig), .upd_done(upd_done), .ctrlupd_req(ctrlupd_req), .ctrlupd_ack(ctrlupd_ack),
        .phyupd_req(phyupd_req), .phyupd_ack(phyupd_ack), .phymstr_req(phymstr_req),
        .phymstr_ack(phymstr_ack), .lp_trig(lp_trig), .lp_wakeup_cfg(lp_wakeup_cfg),
        .lp_ctrl_req(lp_ctrl_req), .lp_ctrl_wakeup(lp_ctrl_wakeup), .lp_ctrl_ack(lp_ctrl_ack),
        .mc_quiesce(mc_quiesce), .mc_idle(mc_idle), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    logic mon_en = 1'b0;

    typedef struct { int cyc; logic [14:0] v; } ev_t;
    ev_t exp_q[$];

    // expected output model, edited by stimulus in chronological order
    logic [2:0] e_err = 3'b000;
    logic       e_done = 0, e_cu = 0, e_pu = 0, e_pm = 0, e_lp = 0, e_q = 0;
    logic [5:0] e_wk = 6'd0;

    logic [14:0] act;
    assign act = {err_timeout, upd_done, ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req,
                  mc_quiesce, lp_ctrl_wakeup};

    task automatic push(input int t);
        ev_t e;
        e.cyc = t;
        e.v   = {e_err, e_done, e_cu, e_pu, e_pm, e_lp, e_q, e_wk};
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin : monitor
        logic [14:0] prev;
        ev_t e;
        prev = '0;
        wait (mon_en);
        forever begin
            @(negedge clock);
            checks++;
            if ((phyupd_ack && phymstr_ack) || (ctrlupd_req && phyupd_ack) ||
                (init_start && (ctrlupd_req || lp_ctrl_req || phyupd_ack || phymstr_ack))) begin
                failures++;
                $display("FAIL invariant cyc=%0d got=%h required no forbidden pair", cyc, act);
            end
            if (act !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required no change", cyc, act);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.v !== act) begin
                        failures++;
                        $display("FAIL event cyc=%0d got=%h required cyc=%0d vec=%h", cyc, act, e.cyc, e.v);
                    end
                end
                prev = act;
            end
        end
    end

    initial begin : watchdog
        #100000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        int c;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (act !== 15'h0) begin
            failures++;
            $display("FAIL reset got=%h required=%h", act, 15'h0);
        end
        reset  = 1'b1;
        mon_en = 1'b1;
        @(posedge clock); #1;

        // T1: blocked until init_complete, then ctrlupd with ack 3 cycles after req
        c = cyc; upd_trig = 1;
        e_cu = 1; push(c+4); e_cu = 0; push(c+12); e_done = 1; push(c+15); e_done = 0; push(c+16);
        wait_until(c+3);  init_complete = 1;
        wait_until(c+7);  ctrlupd_ack = 1;
        wait_until(c+14); ctrlupd_ack = 0;
        wait_until(c+15); upd_trig = 0;
        wait_until(c+20);

        // T2: ctrlupd_ack never comes
        c = cyc; upd_trig = 1;
        e_cu = 1; push(c+1); e_cu = 0; e_done = 1; e_err[0] = 1; push(c+65); e_done = 0; push(c+66);
        wait_until(c+65); upd_trig = 0;
        wait_until(c+68);

        // T3: phyupd with drain finishing after 5 cycles
        c = cyc; phyupd_req = 1;
        e_q = 1; push(c+1); e_pu = 1; push(c+6); e_pu = 0; e_q = 0; push(c+10);
        wait_until(c+5);  mc_idle = 1;
        wait_until(c+9);  phyupd_req = 0;
        wait_until(c+10); mc_idle = 0;
        wait_until(c+13);

        // T4: simultaneous phymstr and phyupd, phymstr first
        c = cyc; mc_idle = 1; phyupd_req = 1; phymstr_req = 1;
        e_q = 1; push(c+1); e_pm = 1; push(c+2); e_pm = 0; e_q = 0; push(c+6);
        e_q = 1; push(c+7); e_pu = 1; push(c+8); e_pu = 0; e_q = 0; push(c+11);
        wait_until(c+5);  phymstr_req = 0;
        wait_until(c+10); phyupd_req = 0;
        wait_until(c+11); mc_idle = 0;
        wait_until(c+14);

        // T5: lp timeout, wakeup must not follow cfg while req is high
        c = cyc; lp_trig = 1; lp_wakeup_cfg = 6'h0A;
        e_lp = 1; e_wk = 6'h0A; push(c+1); e_lp = 0; e_err[2] = 1; push(c+9);
        wait_until(c+2); lp_trig = 0;
        wait_until(c+3); lp_wakeup_cfg = 6'h15;
        wait_until(c+12);

        // T6: phyupd preempts LP_ACT
        c = cyc; lp_trig = 1;
        e_lp = 1; e_wk = 6'h15; push(c+1); e_lp = 0; push(c+6);
        e_q = 1; push(c+10); e_pu = 1; push(c+11); e_pu = 0; e_q = 0; push(c+14);
        wait_until(c+2);  lp_ctrl_ack = 1;
        wait_until(c+5);  phyupd_req = 1;
        wait_until(c+6);  lp_trig = 0;
        wait_until(c+8);  lp_ctrl_ack = 0; mc_idle = 1;
        wait_until(c+13); phyupd_req = 0;
        wait_until(c+14); mc_idle = 0;
        wait_until(c+17);

        // T6b: init_start during CU_HOLD drops req at once, no upd_done, retry afterwards
        c = cyc; upd_trig = 1;
        e_cu = 1; push(c+1); e_cu = 0; push(c+4); e_cu = 1; push(c+9); e_cu = 0; push(c+15);
        e_done = 1; push(c+16); e_done = 0; push(c+17);
        wait_until(c+2);  ctrlupd_ack = 1;
        wait_until(c+4);  init_start = 1;
        wait_until(c+5);  ctrlupd_ack = 0;
        wait_until(c+8);  init_start = 0;
        wait_until(c+10); ctrlupd_ack = 1;
        wait_until(c+15); ctrlupd_ack = 0;
        wait_until(c+16); upd_trig = 0;
        wait_until(c+19);

        // T7: phymstr drain never completes, ack forced at the window edge
        c = cyc; phymstr_req = 1;
        e_q = 1; push(c+1); e_pm = 1; e_err[1] = 1; push(c+32); e_pm = 0; e_q = 0; push(c+35);
        wait_until(c+34); phymstr_req = 0;
        wait_until(c+38);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending events required=0 next_cyc=%0d", exp_q.size(), exp_q[0].cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
